// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
//   mult/multu occupy the unit for 5 cycles and div/divu for 10. The result
//   is written to HI/LO in one step at the final busy edge, so partial values
//   are never visible. mthi/mtlo write HI/LO directly at the accepting edge.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   start      in   1   E-stage instruction is an MDU op this cycle
//   op         in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 7 reserved (none)
//   a          in  32   rs operand
//   b          in  32   rt operand
//   busy       out  1   multi-cycle op in progress (feeds the stall logic)
//   hi         out 32   architectural HI
//   lo         out 32   architectural LO
//   done       out  1   one-cycle pulse in the first IDLE cycle after commit
//   state_dbg  out  2   current FSM state (0 IDLE, 1 MUL, 2 DIV), debug only
//
// Handshake: an op is taken at a rising edge when start=1, the unit is IDLE
// and op is 1..6. There is no back-pressure input; while busy=1 every start
// is dropped, and the pipeline stall logic must hold the instruction until
// busy falls.
// -----------------------------------------------------------------------------
module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  count_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        signed_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   // Result datapath, evaluated from the latched operands only.
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic        q_neg;
   logic        r_neg;
   logic        div_zero;
   logic [31:0] hi_d;
   logic [31:0] lo_d;
   logic        wr_d;

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed division is done on magnitudes and the signs are patched back:
   // the quotient truncates toward zero and the remainder follows the
   // dividend. 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0
   // because the magnitude 0x80000000 re-reads as itself.
   always_comb begin
      a_mag    = (signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
      b_mag    = (signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
      div_zero = (b_q == 32'd0);
      q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
      r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
      q_neg    = signed_q && (a_q[31] ^ b_q[31]);
      r_neg    = signed_q && a_q[31];
   end

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      wr_d = 1'b0;
      if (state_q == S_MUL) begin
         hi_d = signed_q ? prod_s[63:32] : prod_u[63:32];
         lo_d = signed_q ? prod_s[31:0]  : prod_u[31:0];
         wr_d = 1'b1;
      end else if (state_q == S_DIV) begin
         hi_d = r_neg ? (32'd0 - r_mag) : r_mag;
         lo_d = q_neg ? (32'd0 - q_mag) : q_mag;
         // Divide by zero still runs the full latency but leaves HI/LO alone.
         wr_d = !div_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         count_q  <= 4'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         signed_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     3'd1, 3'd2: begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= (op == 3'd1);
                        count_q  <= 4'd5;
                        state_q  <= S_MUL;
                     end
                     3'd3, 3'd4: begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= (op == 3'd3);
                        count_q  <= 4'd10;
                        state_q  <= S_DIV;
                     end
                     3'd5:    hi_q <= a;
                     3'd6:    lo_q <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               count_q <= count_q - 4'd1;
               if (count_q == 4'd1) begin
                  if (wr_d) begin
                     hi_q <= hi_d;
                     lo_q <= lo_d;
                  end
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit. The driver pushes the expected {HI,LO}
//   of each mult/div into exp_q when it issues the op; an independent monitor
//   pops and compares on every done pulse. Busy length, HI/LO hold while
//   busy, mthi/mtlo, reserved ops and reset abort are checked by the driver.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q[$];
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   mul_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checks ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pending result at %0t", $time);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
               n_fail++;
               $display("FAIL result: got hi=0x%08h lo=0x%08h, expected hi=0x%08h lo=0x%08h at %0t",
                        hi, lo, e[63:32], e[31:0], $time);
            end
            model_hi = e[63:32];
            model_lo = e[31:0];
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present an op for one edge, then scramble the operands so any use of
   // unlatched inputs during busy shows up as a wrong result.
   task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'd0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Count busy cycles from now on (sampled at negedge), checking HI/LO hold.
   // Returns at the negedge of the first non-busy cycle.
   task automatic wait_idle(input string name, input int exp_busy);
      int n;
      int guard;
      n     = 0;
      guard = 0;
      @(negedge clk);
      while (busy === 1'b1 && guard < 40) begin
         check32({name, "_hold_hi"}, hi, model_hi);
         check32({name, "_hold_lo"}, lo, model_lo);
         n++;
         guard++;
         @(negedge clk);
      end
      if (guard >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected %0d", name, guard, exp_busy);
      end
      check32({name, "_busy_len"}, n, exp_busy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      op       = 3'd0;
      a        = 32'd0;
      b        = 32'd0;
      model_hi = 32'd0;
      model_lo = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_done", {31'd0, done}, 32'd0);
      check32("rst_hi", hi, 32'd0);
      check32("rst_lo", lo, 32'd0);

      // multu accepted at the very first edge with reset low
      reset = 1'b0;
      exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu", 5);

      // mult -3 * 4
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF4});
      issue(3'd1, 32'hFFFF_FFFD, 32'd4);
      wait_idle("mult", 5);

      // div -7 / 2 -> q=-3, r=-1
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div_neg", 10);

      // divu 7 / 0 -> full latency, HI/LO unchanged
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(3'd4, 32'd7, 32'd0);
      wait_idle("divu_zero", 10);

      // mthi: visible the next cycle, no busy
      issue(3'd5, 32'h1234_5678, 32'd0);
      @(negedge clk);
      check32("mthi_hi", hi, 32'h1234_5678);
      check32("mthi_lo", lo, 32'hFFFF_FFFD);
      check32("mthi_busy", {31'd0, busy}, 32'd0);
      model_hi = 32'h1234_5678;

      // reserved op 7 does nothing
      issue(3'd7, 32'hAAAA_5555, 32'd1);
      @(negedge clk);
      check32("op7_busy", {31'd0, busy}, 32'd0);
      check32("op7_hi", hi, 32'h1234_5678);
      check32("op7_lo", lo, 32'hFFFF_FFFD);

      // overflow case 0x80000000 / -1
      exp_q.push_back({32'h0000_0000, 32'h8000_0000});
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf", 10);

      // divu 100 / 7 -> q=14, r=2
      exp_q.push_back({32'h0000_0002, 32'h0000_000E});
      issue(3'd4, 32'd100, 32'd7);
      wait_idle("divu", 10);

      // div 7 / -2 -> q=-3, r=+1 (remainder follows the dividend)
      exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
      issue(3'd3, 32'd7, 32'hFFFF_FFFE);
      wait_idle("div_rsign", 10);

      // mtlo issued during a mult busy window is ignored
      exp_q.push_back({32'h0000_0001, 32'h0000_0000});
      issue(3'd1, 32'h0001_0000, 32'h0001_0000);
      start = 1'b1;
      op    = 3'd6;
      a     = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'd0;
      wait_idle("mult_mtlo", 3);

      // reset at busy cycle 4 of a divu aborts it: no write, no done
      issue(3'd4, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check32("abort_busy", {31'd0, busy}, 32'd0);
      check32("abort_done", {31'd0, done}, 32'd0);
      check32("abort_hi", hi, 32'd0);
      check32("abort_lo", lo, 32'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      repeat (12) @(negedge clk);

      // back-to-back mult with start held high
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
      exp_q.push_back({32'h0000_0000, 32'h0000_002A});
      start = 1'b1;
      op    = 3'd1;
      a     = 32'hFFFF_FFFE;
      b     = 32'd3;
      @(posedge clk);
      #1;
      a = 32'd6;
      b = 32'd7;
      wait_idle("b2b_first", 5);
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'd0;
      wait_idle("b2b_second", 5);

      repeat (3) @(negedge clk);
      check32("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
